// File: rtl/univ_shift_reg.sv
// Universal shift register: bidirectional serial shift, parallel load, enable/hold,
// and a frame counter that pulses frame_done after every WIDTH completed shifts.
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             vld_p0;

  function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v,
                                                   input logic s);
    return {s, v[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v,
                                                  input logic s);
    return {v[WIDTH-2:0], s};
  endfunction

  // The frame wraps on an explicit compare so non-power-of-two widths count 0..WIDTH-1.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c);
    return (c == CNT_LAST) ? '0 : c + CNT_W'(1);
  endfunction

  // Stage p0: register contents, frame position and frame-complete pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      q_p0   <= '0;
      cnt_p0 <= '0;
      vld_p0 <= 1'b0;
    end else if (!en) begin
      vld_p0 <= 1'b0;
    end else begin
      case (mode)
        MODE_RIGHT: begin
          q_p0   <= shift_right(q_p0, sin_r);
          cnt_p0 <= next_cnt(cnt_p0);
          vld_p0 <= (cnt_p0 == CNT_LAST);
        end
        MODE_LEFT: begin
          q_p0   <= shift_left(q_p0, sin_l);
          cnt_p0 <= next_cnt(cnt_p0);
          vld_p0 <= (cnt_p0 == CNT_LAST);
        end
        MODE_LOAD: begin
          q_p0   <= pin;
          cnt_p0 <= '0;
          vld_p0 <= 1'b0;
        end
        default: begin
          vld_p0 <= 1'b0;
        end
      endcase
    end
  end

  assign q          = q_p0;
  assign sout_r     = q_p0[0];
  assign sout_l     = q_p0[WIDTH-1];
  assign shift_cnt  = cnt_p0;
  assign frame_done = vld_p0;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: WIDTH=4 and WIDTH=5 instances driven in lockstep,
// checked against fixed vector tables and an arithmetic reference model.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sin_r = 1'b0;
  logic       sin_l = 1'b0;
  logic [4:0] pin = '0;

  logic [3:0] q4;
  logic       sr4, sl4, fd4;
  logic [1:0] cnt4;
  logic [4:0] q5;
  logic       sr5, sl5, fd5;
  logic [2:0] cnt5;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, index 0 -> WIDTH=4, index 1 -> WIDTH=5
  int unsigned mq[2];
  int          mpos[2];
  int          mdone[2];
  int          mw[2];

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .pin(pin[3:0]), .q(q4), .sout_r(sr4), .sout_l(sl4), .shift_cnt(cnt4),
    .frame_done(fd4)
  );

  univ_shift_reg #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .pin(pin), .q(q5), .sout_r(sr5), .sout_l(sl5), .shift_cnt(cnt5),
    .frame_done(fd5)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sin_r;
    logic       sin_l;
    logic [3:0] pin;
    logic [3:0] exp_q;
    logic [1:0] exp_cnt;
    logic       exp_done;
  } vec_t;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model works on the register as an integer: shifts are plain arithmetic,
  // the frame is a count of shifts seen since the last reset/load.
  task automatic model_edge(input logic r, input logic e, input logic [1:0] m,
                            input logic sr, input logic sl, input logic [4:0] p);
    for (int k = 0; k < 2; k++) begin
      int unsigned mask;
      mask = (1 << mw[k]) - 1;
      if (r) begin
        mq[k] = 0; mpos[k] = 0; mdone[k] = 0;
      end else if (!e || m == 2'd0) begin
        mdone[k] = 0;
      end else if (m == 2'd3) begin
        mq[k] = p & mask; mpos[k] = 0; mdone[k] = 0;
      end else begin
        if (m == 2'd1) mq[k] = (mq[k] / 2) + (sr ? (1 << (mw[k] - 1)) : 0);
        else           mq[k] = ((mq[k] * 2) + (sl ? 1 : 0)) & mask;
        mpos[k] = mpos[k] + 1;
        mdone[k] = (mpos[k] == mw[k]) ? 1 : 0;
        if (mpos[k] == mw[k]) mpos[k] = 0;
      end
    end
  endtask

  task automatic check_model();
    chk("w4_q",      q4,   mq[0]);
    chk("w4_cnt",    cnt4, mpos[0]);
    chk("w4_done",   fd4,  mdone[0]);
    chk("w4_sout_r", sr4,  mq[0] & 1);
    chk("w4_sout_l", sl4,  (mq[0] >> 3) & 1);
    chk("w5_q",      q5,   mq[1]);
    chk("w5_cnt",    cnt5, mpos[1]);
    chk("w5_done",   fd5,  mdone[1]);
    chk("w5_sout_r", sr5,  mq[1] & 1);
    chk("w5_sout_l", sl5,  (mq[1] >> 4) & 1);
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic sr, input logic sl, input logic [4:0] p);
    rst = r; en = e; mode = m; sin_r = sr; sin_l = sl; pin = p;
    @(posedge clk);
    model_edge(r, e, m, sr, sl, p);
    #1;
    check_model();
  endtask

  vec_t tbl[$];

  initial begin
    mw[0] = 4; mw[1] = 5;
    for (int k = 0; k < 2; k++) begin mq[k] = 0; mpos[k] = 0; mdone[k] = 0; end

    // rst en mode sr sl pin | q cnt done
    // Reset then SISO right, sin_r = 1,0,1,1
    tbl.push_back('{1, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 2'd0, 0});
    tbl.push_back('{0, 1, 2'b01, 1, 0, 4'h0, 4'b1000, 2'd1, 0});
    tbl.push_back('{0, 1, 2'b01, 0, 0, 4'h0, 4'b0100, 2'd2, 0});
    tbl.push_back('{0, 1, 2'b01, 1, 0, 4'h0, 4'b1010, 2'd3, 0});
    tbl.push_back('{0, 1, 2'b01, 1, 0, 4'h0, 4'b1101, 2'd0, 1});
    tbl.push_back('{0, 1, 2'b00, 0, 0, 4'h0, 4'b1101, 2'd0, 0});
    // Load 1001 then shift left with sin_l = 0
    tbl.push_back('{0, 1, 2'b11, 0, 0, 4'h9, 4'b1001, 2'd0, 0});
    tbl.push_back('{0, 1, 2'b10, 0, 0, 4'h0, 4'b0010, 2'd1, 0});
    tbl.push_back('{0, 1, 2'b10, 0, 0, 4'h0, 4'b0100, 2'd2, 0});
    tbl.push_back('{0, 1, 2'b10, 0, 0, 4'h0, 4'b1000, 2'd3, 0});
    tbl.push_back('{0, 1, 2'b10, 0, 0, 4'h0, 4'b0000, 2'd0, 1});
    // Load 0110, two right shifts, en=0 x3, hold x2, two more shifts
    tbl.push_back('{0, 1, 2'b11, 0, 0, 4'h6, 4'b0110, 2'd0, 0});
    tbl.push_back('{0, 1, 2'b01, 0, 0, 4'h0, 4'b0011, 2'd1, 0});
    tbl.push_back('{0, 1, 2'b01, 0, 0, 4'h0, 4'b0001, 2'd2, 0});
    tbl.push_back('{0, 0, 2'b01, 1, 1, 4'hF, 4'b0001, 2'd2, 0});
    tbl.push_back('{0, 0, 2'b11, 1, 1, 4'hF, 4'b0001, 2'd2, 0});
    tbl.push_back('{0, 0, 2'b10, 1, 1, 4'hF, 4'b0001, 2'd2, 0});
    tbl.push_back('{0, 1, 2'b00, 1, 1, 4'hF, 4'b0001, 2'd2, 0});
    tbl.push_back('{0, 1, 2'b00, 1, 1, 4'hF, 4'b0001, 2'd2, 0});
    tbl.push_back('{0, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 2'd3, 0});
    tbl.push_back('{0, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 2'd0, 1});
    // Three shifts, reset mid-frame with mode=01, then a full frame
    tbl.push_back('{0, 1, 2'b01, 1, 0, 4'h0, 4'b1000, 2'd1, 0});
    tbl.push_back('{0, 1, 2'b01, 1, 0, 4'h0, 4'b1100, 2'd2, 0});
    tbl.push_back('{0, 1, 2'b01, 1, 0, 4'h0, 4'b1110, 2'd3, 0});
    tbl.push_back('{1, 1, 2'b01, 1, 0, 4'h0, 4'b0000, 2'd0, 0});
    tbl.push_back('{0, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 2'd1, 0});
    tbl.push_back('{0, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 2'd2, 0});
    tbl.push_back('{0, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 2'd3, 0});
    tbl.push_back('{0, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 2'd0, 1});
    // Mixed direction then reload
    tbl.push_back('{0, 1, 2'b01, 1, 0, 4'h0, 4'b1000, 2'd1, 0});
    tbl.push_back('{0, 1, 2'b01, 0, 0, 4'h0, 4'b0100, 2'd2, 0});
    tbl.push_back('{0, 1, 2'b10, 0, 1, 4'h0, 4'b1001, 2'd3, 0});
    tbl.push_back('{0, 1, 2'b11, 0, 0, 4'hF, 4'b1111, 2'd0, 0});
    tbl.push_back('{0, 1, 2'b00, 0, 0, 4'h0, 4'b1111, 2'd0, 0});

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      step(v.rst, v.en, v.mode, v.sin_r, v.sin_l, {1'b0, v.pin});
      chk("tbl_q",      q4,   v.exp_q);
      chk("tbl_cnt",    cnt4, v.exp_cnt);
      chk("tbl_done",   fd4,  v.exp_done);
      chk("tbl_sout_r", sr4,  v.exp_q[0]);
      chk("tbl_sout_l", sl4,  v.exp_q[3]);
    end

    // WIDTH=5: continuous right shifts, pulses after edges 5 and 10
    step(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0);
    chk("w5_reset_cnt", cnt5, 0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 2'b01, 1'($urandom_range(0, 1)), 1'b0, 5'd0);
      chk("w5_regr_cnt",  cnt5, (i + 1) % 5);
      chk("w5_regr_done", fd5,  (i == 4 || i == 9) ? 1 : 0);
    end
    step(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0);
    chk("w5_regr_done_drop", fd5, 0);

    // Serial latency: a marker bit entering sin_r reaches sout_r after WIDTH edges
    step(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 5'd0);
    for (int i = 1; i < 5; i++) begin
      if (i < 4) chk("w4_lat_early", sr4, 0);
      step(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0);
    end
    chk("w5_lat_arrive", sr5, 1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic r, e;
      logic [1:0] m;
      r = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 7) != 0);
      m = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3))
                                      : 2'($urandom_range(1, 2));
      step(r, e, m, 1'($urandom), 1'($urandom), 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
